spi_slave_wr_decoder: RTL

- SPI-slave front-end that turns single-lane SPI write frames (8-bit cmd, 32-bit addr, 32-bit data, MSB first, SPI mode 0) into memory write requests on the system clock.
- Sits directly downstream of the spi_sclk/spi_cs/spi_sdi0 pads.
- Feeds the on-chip instruction/data memory used for program preload before fetch enable.
- SPI signals are oversampled in the clk_i domain; no second clock exists.

---
 rtl/spi_slave_wr_decoder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/spi_slave_wr_decoder.sv
// SPI-slave write decoder: oversamples a mode-0 SPI link on clk_i and turns
// cmd/addr/data frames into valid/ready memory write requests. Optional macro: SPI_WR_AUTOINC_EN.
module spi_slave_wr_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [7:0]  WRITE_CMD   = 8'h02
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spi_sclk_i,
  input  logic                  spi_cs_i,
  input  logic                  spi_sdi0_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [ADDR_WIDTH-1:0] req_addr_o,
  output logic [DATA_WIDTH-1:0] req_wdata_o,
  output logic                  cmd_err_o,
  output logic                  overrun_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_ADDR    = 3'd2,
    S_DATA    = 3'd3,
    S_DISCARD = 3'd4
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   sdi_s;
  logic                   sclk_rise;

  state_e                 state_q;
  logic [5:0]             cnt_q;
  logic [30:0]            shift_q;
  logic [31:0]            shift_d;
  logic                   field_done;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  req_addr_q;
  logic [DATA_WIDTH-1:0]  req_wdata_q;
  logic                   req_valid_q;
  logic                   issue_q;
  logic                   cmd_err_q;
  logic                   overrun_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sdi_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi0_i};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign sdi_s      = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_prev_q;
  assign shift_d    = {shift_q, sdi_s};
  assign field_done = (state_q == S_CMD) ? (cnt_q == 6'd7) : (cnt_q == 6'd31);

  // Requests are staged through issue_q so valid rises one cycle after the
  // last data bit is captured, with addr/data already stable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_valid_q <= 1'b0;
      issue_q     <= 1'b0;
      cmd_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cmd_err_q <= 1'b0;
      overrun_q <= 1'b0;
      issue_q   <= 1'b0;

      if (issue_q) begin
        req_valid_q <= 1'b1;
      end else if (req_valid_q && req_ready_i) begin
        req_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (!cs_s) begin
            state_q <= S_CMD;
            cnt_q   <= '0;
          end
        end
        S_DISCARD: begin
          if (cs_s) state_q <= S_IDLE;
        end
        default: begin
          if (cs_s) begin
            state_q <= S_IDLE;
          end else if (sclk_rise) begin
            shift_q <= shift_d[30:0];
            cnt_q   <= cnt_q + 6'd1;
            if (field_done) begin
              cnt_q <= '0;
              if (state_q == S_CMD) begin
                if (shift_d[7:0] == WRITE_CMD) begin
                  state_q <= S_ADDR;
                end else begin
                  cmd_err_q <= 1'b1;
                  state_q   <= S_DISCARD;
                end
              end else if (state_q == S_ADDR) begin
                addr_q  <= shift_d;
                state_q <= S_DATA;
              end else begin
                if (req_valid_q) begin
                  overrun_q <= 1'b1;
                end else begin
                  req_addr_q  <= addr_q;
                  req_wdata_q <= shift_d;
                  issue_q     <= 1'b1;
                end
`ifdef SPI_WR_AUTOINC_EN
                addr_q <= addr_q + ADDR_WIDTH'(4);
`else
                state_q <= S_DISCARD;
`endif
              end
            end
          end
        end
      endcase
    end
  end

  assign req_valid_o = req_valid_q;
  assign req_addr_o  = req_addr_q;
  assign req_wdata_o = req_wdata_q;
  assign cmd_err_o   = cmd_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != S_IDLE) | req_valid_q;

endmodule
